// File: rtl/rmii_rx_deser.sv
// RMII receive front end: preamble/SFD detection and MSB-first dibit-to-word deserialiser.
// Define RMII_RX_STATS_EN to add saturating frame/error/overflow statistics counters.
module rmii_rx_deser #(
    parameter int PREAMBLE_MIN = 4,
    parameter int CNT_W        = 16
) (
    input  logic        clk_25_mhz,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    input  logic        rx_read,
    output logic [31:0] rx_buf,
    output logic        rx_full,
    output logic [4:0]  rx_dibits,
    output logic        rx_frame_end,
    output logic        rx_err,
    output logic        rx_overflow
`ifdef RMII_RX_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_errors,
    output logic [CNT_W-1:0] stat_overflows
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [3:0] PRE_MIN = 4'(PREAMBLE_MIN);
    localparam logic [3:0] PRE_MAX = 4'hF;

    state_t      state, state_next;
    logic [3:0]  pre_cnt, pre_cnt_next;
    logic [4:0]  dib_cnt, dib_cnt_next;
    logic [31:0] shreg, shreg_next;
    logic        word_done;
    logic [31:0] word_data;
    logic [4:0]  word_dibits;
    logic [5:0]  pad_bits;
    logic        frame_end_set;
    logic        err_set;

    always_ff @(posedge clk_25_mhz or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
            dib_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            pre_cnt <= pre_cnt_next;
            dib_cnt <= dib_cnt_next;
            shreg   <= shreg_next;
        end
    end

    // Stale high bits of shreg are harmless: a partial word is shifted so only
    // the dib_cnt freshest dibits survive at the top.
    assign pad_bits = 6'd32 - {dib_cnt, 1'b0};

    always_comb begin
        state_next    = state;
        pre_cnt_next  = pre_cnt;
        dib_cnt_next  = dib_cnt;
        shreg_next    = shreg;
        word_done     = 1'b0;
        word_data     = '0;
        word_dibits   = dib_cnt;
        frame_end_set = 1'b0;
        err_set       = 1'b0;

        case (state)
            IDLE: begin
                if (crs_dv) begin
                    if (rx_d == 2'b01) begin
                        state_next   = PREAMBLE;
                        pre_cnt_next = 4'd1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!crs_dv) begin
                    state_next = IDLE;
                end else if (rx_d == 2'b01) begin
                    if (pre_cnt != PRE_MAX) begin
                        pre_cnt_next = pre_cnt + 4'd1;
                    end
                end else if (rx_d == 2'b11 && pre_cnt >= PRE_MIN) begin
                    state_next   = DATA;
                    dib_cnt_next = '0;
                end else begin
                    state_next = DROP;
                    err_set    = 1'b1;
                end
            end
            DATA: begin
                if (!crs_dv) begin
                    state_next    = IDLE;
                    frame_end_set = 1'b1;
                    if (dib_cnt != 5'd0) begin
                        word_done = 1'b1;
                        word_data = shreg << pad_bits;
                    end
                end else if (rx_er) begin
                    state_next   = DROP;
                    err_set      = 1'b1;
                    dib_cnt_next = '0;
                end else begin
                    shreg_next = {shreg[29:0], rx_d};
                    if (dib_cnt == 5'd15) begin
                        word_done    = 1'b1;
                        word_data    = {shreg[29:0], rx_d};
                        word_dibits  = 5'd16;
                        dib_cnt_next = '0;
                    end else begin
                        dib_cnt_next = dib_cnt + 5'd1;
                    end
                end
            end
            DROP: begin
                if (!crs_dv) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A finished word loads if the buffer is free or being read this cycle;
    // otherwise it is dropped and the held word stays intact.
    always_ff @(posedge clk_25_mhz or posedge rst) begin
        if (rst) begin
            rx_buf       <= '0;
            rx_full      <= 1'b0;
            rx_dibits    <= '0;
            rx_frame_end <= 1'b0;
            rx_err       <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            rx_frame_end <= frame_end_set;
            rx_err       <= err_set;
            rx_overflow  <= 1'b0;
            if (word_done) begin
                if (!rx_full || rx_read) begin
                    rx_buf    <= word_data;
                    rx_dibits <= word_dibits;
                    rx_full   <= 1'b1;
                end else begin
                    rx_overflow <= 1'b1;
                end
            end else if (rx_read) begin
                rx_full <= 1'b0;
            end
        end
    end

`ifdef RMII_RX_STATS_EN
    always_ff @(posedge clk_25_mhz or posedge rst) begin
        if (rst) begin
            stat_frames    <= '0;
            stat_errors    <= '0;
            stat_overflows <= '0;
        end else begin
            if (rx_frame_end && stat_frames != '1) begin
                stat_frames <= stat_frames + 1'b1;
            end
            if (rx_err && stat_errors != '1) begin
                stat_errors <= stat_errors + 1'b1;
            end
            if (rx_overflow && stat_overflows != '1) begin
                stat_overflows <= stat_overflows + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rmii_rx_deser.sv
// Scoreboard bench for rmii_rx_deser: directed frames push expected words, a monitor pops and checks.
module tb_rmii_rx_deser;

    logic        clk_25_mhz = 1'b0;
    logic        rst = 1'b1;
    logic        crs_dv = 1'b0;
    logic [1:0]  rx_d = 2'b00;
    logic        rx_er = 1'b0;
    logic        rx_read = 1'b0;
    logic [31:0] rx_buf;
    logic        rx_full;
    logic [4:0]  rx_dibits;
    logic        rx_frame_end;
    logic        rx_err;
    logic        rx_overflow;
`ifdef RMII_RX_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_errors;
    logic [15:0] stat_overflows;
`endif

    rmii_rx_deser #(.PREAMBLE_MIN(4), .CNT_W(16)) dut (
        .clk_25_mhz   (clk_25_mhz),
        .rst          (rst),
        .crs_dv       (crs_dv),
        .rx_d         (rx_d),
        .rx_er        (rx_er),
        .rx_read      (rx_read),
        .rx_buf       (rx_buf),
        .rx_full      (rx_full),
        .rx_dibits    (rx_dibits),
        .rx_frame_end (rx_frame_end),
        .rx_err       (rx_err),
        .rx_overflow  (rx_overflow)
`ifdef RMII_RX_STATS_EN
        ,
        .stat_frames    (stat_frames),
        .stat_errors    (stat_errors),
        .stat_overflows (stat_overflows)
`endif
    );

    always #20 clk_25_mhz = ~clk_25_mhz;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dibits;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   drive_cyc = 0;
    int   fe_cnt = 0;
    int   err_cnt = 0;
    int   ovf_cnt = 0;
    int   last_fe_cyc = 0;
    int   full_age = 0;
    bit   auto_read = 1'b0;
    bit   prev_full = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: runs 1 time unit after each edge, so rx_read still holds the value that edge saw.
    always @(posedge clk_25_mhz) begin
        #1;
        cyc++;
        if (rx_frame_end) begin
            fe_cnt++;
            last_fe_cyc = cyc;
        end
        if (rx_err) err_cnt++;
        if (rx_overflow) ovf_cnt++;
        if (rx_full && (!prev_full || rx_read)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_word: got %h (%0d dibits), expected none", rx_buf, rx_dibits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("word_data", rx_buf, e.data);
                checkOutput("word_dibits", {27'd0, rx_dibits}, {27'd0, e.dibits});
                checkOutput("word_cycle", cyc, e.cyc);
            end
        end
        prev_full = rx_full;
    end

    task automatic applyStimulus(input logic cdv, input logic [1:0] d, input logic er, input logic rd);
        @(negedge clk_25_mhz);
        if (rx_full) full_age++;
        else full_age = 0;
        rx_read   = rd || (auto_read && full_age == 2);
        crs_dv    = cdv;
        rx_d      = d;
        rx_er     = er;
        drive_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic sendPreamble(input int n, input logic [1:0] sfd);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, sfd, 1'b0, 1'b0);
    endtask

    task automatic sendWord(input logic [31:0] w, input int read_at);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, w[31-2*i -: 2], 1'b0, i == read_at);
    endtask

    task automatic pushWord(input logic [31:0] data, input logic [4:0] dibits);
        exp_t e;
        e.data   = data;
        e.dibits = dibits;
        e.cyc    = drive_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic clearCounts();
        fe_cnt  = 0;
        err_cnt = 0;
        ovf_cnt = 0;
    endtask

    int fe_exp;

    initial begin
        // Reset state
        idle(2);
        checkOutput("reset_buf", rx_buf, 32'h0);
        checkOutput("reset_full", {31'd0, rx_full}, 32'd0);
        checkOutput("reset_dibits", {27'd0, rx_dibits}, 32'd0);
        checkOutput("reset_pulses", {29'd0, rx_frame_end, rx_err, rx_overflow}, 32'd0);
        rst = 1'b0;

        // Single full word, long preamble
        clearCounts();
        auto_read = 1'b1;
        sendPreamble(7, 2'b11);
        sendWord(32'h9229C2C3, -1);
        pushWord(32'h9229C2C3, 5'd16);
        idle(1);
        fe_exp = drive_cyc + 1;
        idle(4);
        checkOutput("t1_frame_end_cnt", fe_cnt, 1);
        checkOutput("t1_frame_end_cyc", last_fe_cyc, fe_exp);
        checkOutput("t1_err_cnt", err_cnt, 0);
        checkOutput("t1_full_cleared", {31'd0, rx_full}, 32'd0);

        // Two words plus a 3-dibit tail, minimum preamble
        clearCounts();
        sendPreamble(4, 2'b11);
        sendWord(32'h9229C2C3, -1);
        pushWord(32'h9229C2C3, 5'd16);
        sendWord(32'h4F524860, -1);
        pushWord(32'h4F524860, 5'd16);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        idle(1);
        pushWord(32'h9C000000, 5'd3);
        idle(5);
        checkOutput("t2_frame_end_cnt", fe_cnt, 1);
        checkOutput("t2_err_cnt", err_cnt, 0);
        checkOutput("t2_ovf_cnt", ovf_cnt, 0);

        // Short preambles (2 and PREAMBLE_MIN-1), then a good frame
        clearCounts();
        sendPreamble(2, 2'b11);
        sendWord(32'h4F524860, -1);
        idle(2);
        sendPreamble(3, 2'b11);
        sendWord(32'h12345678, -1);
        idle(2);
        sendPreamble(5, 2'b11);
        sendWord(32'h4F524860, -1);
        pushWord(32'h4F524860, 5'd16);
        idle(5);
        checkOutput("t3_err_cnt", err_cnt, 2);
        checkOutput("t3_frame_end_cnt", fe_cnt, 1);
        checkOutput("t3_queue_empty", exp_q.size(), 0);

        // rx_er on the 5th data dibit
        clearCounts();
        sendPreamble(6, 2'b11);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        idle(4);
        checkOutput("t4_err_cnt", err_cnt, 1);
        checkOutput("t4_frame_end_cnt", fe_cnt, 0);
        checkOutput("t4_no_word", {31'd0, rx_full}, 32'd0);

        // Overflow: second word dropped while the first is unread
        clearCounts();
        auto_read = 1'b0;
        sendPreamble(4, 2'b11);
        sendWord(32'hA5A50F0F, -1);
        pushWord(32'hA5A50F0F, 5'd16);
        sendWord(32'h12345678, -1);
        idle(3);
        checkOutput("t5_ovf_cnt", ovf_cnt, 1);
        checkOutput("t5_frame_end_cnt", fe_cnt, 1);
        checkOutput("t5_buf_kept", rx_buf, 32'hA5A50F0F);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        idle(2);
        checkOutput("t5_read_clears", {31'd0, rx_full}, 32'd0);

        // Coincident read: second word replaces the first without overflow
        clearCounts();
        sendPreamble(4, 2'b11);
        sendWord(32'hA5A50F0F, -1);
        pushWord(32'hA5A50F0F, 5'd16);
        sendWord(32'h12345678, 15);
        pushWord(32'h12345678, 5'd16);
        idle(3);
        checkOutput("t5b_ovf_cnt", ovf_cnt, 0);
        checkOutput("t5b_buf_new", rx_buf, 32'h12345678);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset mid-DATA with a word held
        clearCounts();
        sendPreamble(4, 2'b11);
        sendWord(32'hDEADBEEF, -1);
        pushWord(32'hDEADBEEF, 5'd16);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        #5 rst = 1'b1;
        #1;
        checkOutput("t6_async_full", {31'd0, rx_full}, 32'd0);
        checkOutput("t6_async_buf", rx_buf, 32'h0);
        checkOutput("t6_async_dibits", {27'd0, rx_dibits}, 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        idle(3);
        checkOutput("t6_no_pulses", fe_cnt + err_cnt + ovf_cnt, 0);

        // Two good frames, one aborted frame, one overflow
        clearCounts();
        auto_read = 1'b1;
        sendPreamble(4, 2'b11);
        sendWord(32'h00000001, -1);
        pushWord(32'h00000001, 5'd16);
        idle(4);
        sendPreamble(1, 2'b00);
        idle(2);
        auto_read = 1'b0;
        sendPreamble(4, 2'b11);
        sendWord(32'hCAFEF00D, -1);
        pushWord(32'hCAFEF00D, 5'd16);
        sendWord(32'h0BADC0DE, -1);
        idle(3);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        idle(3);
        checkOutput("t7_frame_end_cnt", fe_cnt, 2);
        checkOutput("t7_err_cnt", err_cnt, 1);
        checkOutput("t7_ovf_cnt", ovf_cnt, 1);
`ifdef RMII_RX_STATS_EN
        checkOutput("stat_frames", {16'd0, stat_frames}, 32'd2);
        checkOutput("stat_errors", {16'd0, stat_errors}, 32'd1);
        checkOutput("stat_overflows", {16'd0, stat_overflows}, 32'd1);
`endif
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
